// File: rtl/alu_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_scheduler_pkg
// Description : Shared definitions for the ALU scheduler slice. Holds the ALU
//               op-code constants, the scheduler FSM state type and encodings,
//               and the bit positions of the {C,N,Z} flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_scheduler_pkg;

    // ALU operation codes (low four bits of the request op field)
    localparam logic [3:0] C_OP_B     = 4'd0;
    localparam logic [3:0] C_OP_ADD   = 4'd1;
    localparam logic [3:0] C_OP_SUB   = 4'd2;
    localparam logic [3:0] C_OP_AND   = 4'd3;
    localparam logic [3:0] C_OP_OR    = 4'd4;
    localparam logic [3:0] C_OP_XOR   = 4'd5;
    localparam logic [3:0] C_OP_NOT   = 4'd6;
    localparam logic [3:0] C_OP_NEG   = 4'd7;
    localparam logic [3:0] C_OP_LSL   = 4'd8;
    localparam logic [3:0] C_OP_LSR   = 4'd9;
    localparam logic [3:0] C_OP_ASR   = 4'd10;
    localparam logic [3:0] C_OP_SWAP  = 4'd11;
    localparam logic [3:0] C_OP_SWAPN = 4'd12;
    localparam logic [3:0] C_OP_MUL   = 4'd13;

    // Scheduler FSM state type and encodings
    typedef logic [1:0] state_t;
    localparam state_t C_ST_IDLE = 2'd0;
    localparam state_t C_ST_EXEC = 2'd1;
    localparam state_t C_ST_RESP = 2'd2;

    // Bit positions inside the {C,N,Z} flag vector
    localparam int C_FLAG_Z = 0;
    localparam int C_FLAG_N = 1;
    localparam int C_FLAG_C = 2;

endpackage
`default_nettype wire

// File: rtl/alu_scheduler_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 16-bit combinational ALU. Produces the result only; carry
//               derivation is left to the instantiating block.
// Ports       : i_a, i_b - operands
//               i_op     - bit4 = use carry-in, bits3:0 = operation
//               i_ci     - carry-in, honoured only when i_op[4] is set
//               o_y      - result (0 for op-codes 14/15)
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_scheduler_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [4:0]  i_op,
    input  logic        i_ci,
    output logic [15:0] o_y
);

    logic w_ci;
    assign w_ci = i_op[4] & i_ci;

    always_comb begin
        o_y = 16'h0000;
        case (i_op[3:0])
            C_OP_B:     o_y = i_b;
            C_OP_ADD:   o_y = i_a + i_b + {15'd0, w_ci};
            // Subtract-with-carry treats the carry as a borrow
            C_OP_SUB:   o_y = i_a - i_b - {15'd0, w_ci};
            C_OP_AND:   o_y = i_a & i_b;
            C_OP_OR:    o_y = i_a | i_b;
            C_OP_XOR:   o_y = i_a ^ i_b;
            C_OP_NOT:   o_y = ~i_a;
            C_OP_NEG:   o_y = 16'd0 - i_a;
            C_OP_LSL:   o_y = {i_a[14:0], w_ci};
            C_OP_LSR:   o_y = {w_ci, i_a[15:1]};
            C_OP_ASR:   o_y = {i_a[15], i_a[15:1]};
            C_OP_SWAP:  o_y = {i_a[7:0], i_a[15:8]};
            // Swap the two nibbles inside each byte
            C_OP_SWAPN: o_y = {i_a[11:8], i_a[15:12], i_a[3:0], i_a[7:4]};
            C_OP_MUL:   o_y = i_a * i_b;
            default:    o_y = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_scheduler
// Description : Two-requester round-robin front end for a single 16-bit ALU.
//               IDLE grants one request, EXEC runs the ALU (MUL_CYCLES for
//               MUL, one cycle otherwise), RESP presents the result to the
//               owning requester until it is taken.
// Ports       : clk, rst_n            - clock, async active-low reset
//               req_valid/req_ready   - per-requester request handshake
//               req_a, req_b, req_op  - per-requester operands and op
//               rsp_valid/rsp_ready   - per-requester response handshake
//               rsp_y, rsp_err        - shared result and illegal-op flag
//               flags                 - {C,N,Z} of last completed legal op
//               busy                  - scheduler not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int MUL_CYCLES = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][15:0] req_a,
    input  logic [1:0][15:0] req_b,
    input  logic [1:0][4:0]  req_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [15:0]      rsp_y,
    output logic             rsp_err,
    output logic [2:0]       flags,
    output logic             busy
);

    state_t      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [4:0]  r_op;
    logic        r_id;
    logic        r_prio;     // requester that wins the next contention
    logic [1:0]  r_cnt;
    logic [15:0] r_y;
    logic        r_err;
    logic [2:0]  r_flags;

    logic        w_any;
    logic        w_gid;
    logic        w_accept;
    logic        w_ci;
    logic        w_c;
    logic        w_illegal;
    logic [15:0] w_alu_y;

    // Grant: lone requester wins; on contention the priority pointer decides
    assign w_any    = |req_valid;
    assign w_gid    = (req_valid == 2'b11) ? r_prio : req_valid[1];
    assign w_accept = (r_state == C_ST_IDLE) && w_any;

    // Ready is masked by rst_n so it drops immediately on reset assertion
    assign req_ready[0] = rst_n && w_accept && (w_gid == 1'b0);
    assign req_ready[1] = rst_n && w_accept && (w_gid == 1'b1);

    assign rsp_valid[0] = (r_state == C_ST_RESP) && (r_id == 1'b0);
    assign rsp_valid[1] = (r_state == C_ST_RESP) && (r_id == 1'b1);
    assign busy         = (r_state != C_ST_IDLE);
    assign rsp_y        = r_y;
    assign rsp_err      = r_err;
    assign flags        = r_flags;

    assign w_ci      = r_flags[C_FLAG_C] & r_op[4];
    assign w_illegal = (r_op[3:1] == 3'b111);

    alu u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .i_ci (r_flags[C_FLAG_C]),
        .o_y  (w_alu_y)
    );

    // Carry: bit 16 of the 17-bit add/sub, shifted-out bit for LSL/LSR
    always_comb begin
        w_c = 1'b0;
        case (r_op[3:0])
            C_OP_ADD: w_c = 1'(({1'b0, r_a} + {1'b0, r_b} + {16'd0, w_ci}) >> 16);
            C_OP_SUB: w_c = 1'(({1'b0, r_a} - {1'b0, r_b} - {16'd0, w_ci}) >> 16);
            C_OP_LSL: w_c = r_a[15];
            C_OP_LSR: w_c = r_a[0];
            default:  w_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_op    <= 5'd0;
            r_id    <= 1'b0;
            r_prio  <= 1'b0;
            r_cnt   <= 2'd0;
            r_y     <= 16'h0000;
            r_err   <= 1'b0;
            r_flags <= 3'b000;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a[w_gid];
                        r_b     <= req_b[w_gid];
                        r_op    <= req_op[w_gid];
                        r_id    <= w_gid;
                        r_prio  <= ~w_gid;
                        // Counter holds the number of EXEC cycles still to go
                        r_cnt   <= (req_op[w_gid][3:0] == C_OP_MUL) ?
                                   2'(MUL_CYCLES - 1) : 2'd0;
                        r_state <= C_ST_EXEC;
                    end
                end
                C_ST_EXEC: begin
                    if (r_cnt == 2'd0) begin
                        r_err   <= w_illegal;
                        r_y     <= w_illegal ? 16'h0000 : w_alu_y;
                        if (!w_illegal) begin
                            r_flags[C_FLAG_C] <= w_c;
                            r_flags[C_FLAG_N] <= w_alu_y[15];
                            r_flags[C_FLAG_Z] <= (w_alu_y == 16'h0000);
                        end
                        r_state <= C_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                C_ST_RESP: begin
                    if (rsp_ready[r_id]) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_scheduler
// Description : Self-checking bench for alu_scheduler: directed scenarios
//               followed by randomized single requests compared against an
//               arithmetic reference model of the ALU and flag rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_scheduler;

    localparam int MUL_CYCLES = 2;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][15:0] req_a;
    logic [1:0][15:0] req_b;
    logic [1:0][4:0]  req_op;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [15:0]      rsp_y;
    logic             rsp_err;
    logic [2:0]       flags;
    logic             busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  ref_flags;   // {C,N,Z}

    alu_scheduler #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .flags     (flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int swap_nib(input int x);
        return (x % 16) * 16 + x / 16;
    endfunction

    // Reference: plain arithmetic on integers, flags updated for legal ops
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                         output logic [15:0] y, output logic err);
        longint t;
        longint ai;
        longint bi;
        int     ci;
        logic   c;
        ai  = longint'(a);
        bi  = longint'(b);
        ci  = op[4] ? int'(ref_flags[2]) : 0;
        c   = 1'b0;
        err = 1'b0;
        t   = 0;
        case (int'(op[3:0]))
            0:  t = bi;
            1:  begin t = ai + bi + ci; c = (t >= 65536); end
            2:  begin t = ai - bi - ci; c = (t < 0); end
            3:  t = ai & bi;
            4:  t = ai | bi;
            5:  t = ai ^ bi;
            6:  t = 65535 - ai;
            7:  t = 65536 - ai;
            8:  begin t = ai * 2 + ci; c = (ai >= 32768); end
            9:  begin t = ai / 2 + ci * 32768; c = (ai % 2 == 1); end
            10: t = ai / 2 + ((ai >= 32768) ? 32768 : 0);
            11: t = (ai % 256) * 256 + ai / 256;
            12: t = swap_nib(int'(ai / 256)) * 256 + swap_nib(int'(ai % 256));
            13: t = ai * bi;
            default: err = 1'b1;
        endcase
        y = err ? 16'h0000 : t[15:0];
        if (!err) ref_flags = {c, y[15], (y == 16'h0000)};
    endtask

    // One isolated transaction: request, latency, result, hold, release
    task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] op, input int hold);
        int          lat;
        logic [15:0] ey;
        logic        ee;
        logic [15:0] y0;
        @(negedge clk);
        req_a[id]     = a;
        req_b[id]     = b;
        req_op[id]    = op;
        req_valid[id] = 1'b1;
        lat = 0;
        #1;
        while (!req_ready[id] && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        check("accept", 32'(req_ready[id]), 32'd1);
        if (!req_ready[id]) begin
            req_valid[id] = 1'b0;
            return;
        end
        model(a, b, op, ey, ee);
        @(negedge clk);
        req_valid[id] = 1'b0;
        lat = 1;
        #1;
        check("busy_exec", 32'(busy), 32'd1);
        while (!rsp_valid[id] && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        check("rsp_latency", 32'(lat), (op[3:0] == 4'd13) ? 32'(1 + MUL_CYCLES) : 32'd2);
        check("rsp_y", 32'(rsp_y), 32'(ey));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("flags", 32'(flags), 32'(ref_flags));
        check("rsp_valid_other", 32'(rsp_valid[1-id]), 32'd0);
        y0 = rsp_y;
        rsp_ready[1-id] = 1'b1;     // non-owner ready must not release RESP
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            check("hold_valid", 32'(rsp_valid[id]), 32'd1);
            check("hold_y", 32'(rsp_y), 32'(y0));
            check("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready[id] = 1'b1;
        @(negedge clk); #1;
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        rsp_ready = 2'b00;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ref_flags = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_acc;
        int last_t;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 2'b00;
        ref_flags = 3'b000;

        // Reset values, with both requesters already asking
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention with rsp_ready tied high: grants alternate, 3-cycle spacing
        req_a[0] = 16'h1111; req_a[1] = 16'h2222;
        req_b[0] = 16'h0010; req_b[1] = 16'h0020;
        rsp_ready = 2'b11;
        n_acc  = 0;
        last_t = 0;
        for (int cyc = 0; cyc < 40 && n_acc < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (req_ready != 2'b00) begin
                check("rr_onehot", 32'($countones(req_ready)), 32'd1);
                check("rr_id", 32'(req_ready[1]), 32'(n_acc % 2));
                if (n_acc > 0) check("rr_spacing", 32'(cyc - last_t), 32'd3);
                last_t = cyc;
                n_acc++;
            end
        end
        check("rr_count", 32'(n_acc), 32'd6);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        rsp_ready = 2'b00;
        pulse_reset();

        // ADD wrapping to zero, then ADC consuming the carry
        run_op(0, 16'hFFFF, 16'h0001, 5'h01, 0);
        check("add_flags", 32'(flags), 32'b101);
        run_op(1, 16'h0001, 16'h0001, 5'h11, 1);
        check("adc_flags", 32'(flags), 32'b000);

        // MUL low half is zero
        run_op(0, 16'h0100, 16'h0100, 5'h0D, 0);
        check("mul_flags", 32'(flags), 32'b001);

        // Illegal op with stalled response
        run_op(1, 16'h1234, 16'h5678, 5'h0E, 5);
        check("err_flags", 32'(flags), 32'b001);

        // Leave nonzero result/flags, then reset mid-EXEC
        run_op(0, 16'hF000, 16'h2000, 5'h01, 0);
        @(negedge clk);
        req_a[0] = 16'h0003; req_b[0] = 16'h0005; req_op[0] = 5'h0D;
        req_valid[0] = 1'b1;
        #1;
        check("abort_accept", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_y", 32'(rsp_y), 32'd0);
        check("abort_rsp_err", 32'(rsp_err), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        ref_flags = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Randomized single requests against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom % 4)
                0:       ra = 16'hFFFF;
                1:       ra = 16'h0000;
                default: ra = 16'($urandom);
            endcase
            case ($urandom % 4)
                0:       rb = 16'h0001;
                1:       rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            run_op(int'($urandom % 2), ra, rb, 5'($urandom_range(0, 31)),
                   int'($urandom % 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
